// File: rtl/mem_swap_ctrl_if.sv
// mem_swap_ctrl_if: control/host bundle for the mem_swap_ctrl swap engine.
//   master (host side):  drives start, mode, addr_a, addr_b, wr_en, wr_addr,
//                        wr_data, rd_addr; receives rd_data, busy, done,
//                        wr_reject, op_cnt.
//   slave (engine side): the mirror image.
interface mem_swap_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              busy;
  logic              done;
  logic              wr_reject;
  logic [CNT_W-1:0]  op_cnt;

  modport master (
    output start, mode, addr_a, addr_b, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, busy, done, wr_reject, op_cnt
  );

  modport slave (
    input  start, mode, addr_a, addr_b, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, busy, done, wr_reject, op_cnt
  );
endinterface

// File: rtl/mem_swap_ctrl.sv
// mem_swap_ctrl: WIDTH x 2**ADDR_W register file with a host write/read port
// and a sequencer that swaps two entries through a temp register (mode=0)
// or copies entry A into entry B (mode=1).
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; clears array, temp, counters
//   bus      mem_swap_ctrl_if.slave:
//              start/mode/addr_a/addr_b  operation request (taken in IDLE)
//              wr_en/wr_addr/wr_data     host write (accepted only in IDLE)
//              rd_addr/rd_data           registered read, read-before-write
//              busy/done/wr_reject       status (all registered)
//              op_cnt                    completed-operation counter (wraps)
module mem_swap_ctrl #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_swap_ctrl_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE, RD_A, WR_A, WR_B, COPY, DONE
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_a_reg;
  logic [ADDR_W-1:0] addr_b_reg;
  logic [WIDTH-1:0]  temp_reg;
  logic [WIDTH-1:0]  rd_data_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              wr_reject_reg;
  logic [CNT_W-1:0]  op_cnt_reg;
  logic [WIDTH-1:0]  mem_reg [DEPTH];

  // Single array write port shared by the host (IDLE only) and the sequencer.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    case (state_reg)
      IDLE: mem_we = bus.wr_en;
      WR_A: begin
        mem_we    = 1'b1;
        mem_waddr = addr_a_reg;
        mem_wdata = mem_reg[addr_b_reg];
      end
      WR_B: begin
        mem_we    = 1'b1;
        mem_waddr = addr_b_reg;
        mem_wdata = temp_reg;
      end
      COPY: begin
        mem_we    = 1'b1;
        mem_waddr = addr_b_reg;
        mem_wdata = mem_reg[addr_a_reg];
      end
      default: mem_we = 1'b0;
    endcase
  end

  // The array must clear on reset, so it is built from flops rather than RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (mem_we) begin
      mem_reg[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      addr_a_reg    <= '0;
      addr_b_reg    <= '0;
      temp_reg      <= '0;
      rd_data_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      wr_reject_reg <= 1'b0;
      op_cnt_reg    <= '0;
    end else begin
      // Old contents are returned even when the same edge writes the entry.
      rd_data_reg   <= mem_reg[bus.rd_addr];
      wr_reject_reg <= bus.wr_en && (state_reg != IDLE);
      done_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            addr_a_reg <= bus.addr_a;
            addr_b_reg <= bus.addr_b;
            busy_reg   <= 1'b1;
            // mode only selects the path, so the state itself holds it.
            if (bus.addr_a == bus.addr_b) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else if (bus.mode) begin
              state_reg <= COPY;
            end else begin
              state_reg <= RD_A;
            end
          end
        end
        RD_A: begin
          temp_reg  <= mem_reg[addr_a_reg];
          state_reg <= WR_A;
        end
        WR_A: state_reg <= WR_B;
        WR_B: begin
          state_reg <= DONE;
          done_reg  <= 1'b1;
        end
        COPY: begin
          state_reg <= DONE;
          done_reg  <= 1'b1;
        end
        DONE: begin
          op_cnt_reg <= op_cnt_reg + 1'b1;
          state_reg  <= IDLE;
          busy_reg   <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_data   = rd_data_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.wr_reject = wr_reject_reg;
  assign bus.op_cnt    = op_cnt_reg;
endmodule

// File: tb/tb_mem_swap_ctrl.sv
// tb_mem_swap_ctrl: directed + randomized bench for mem_swap_ctrl. A
// transaction-level model (array + per-operation step count) predicts every
// output each cycle; a second instance built with CNT_W=2 shares the stimulus
// to exercise counter wrap.
module tb_mem_swap_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_swap_ctrl_if #(.WIDTH(8), .ADDR_W(4), .CNT_W(16)) bus ();
  mem_swap_ctrl_if #(.WIDTH(8), .ADDR_W(4), .CNT_W(2))  bus2 ();

  mem_swap_ctrl #(.WIDTH(8), .ADDR_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  mem_swap_ctrl #(.WIDTH(8), .ADDR_W(4), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2));

  assign bus2.start   = bus.start;
  assign bus2.mode    = bus.mode;
  assign bus2.addr_a  = bus.addr_a;
  assign bus2.addr_b  = bus.addr_b;
  assign bus2.wr_en   = bus.wr_en;
  assign bus2.wr_addr = bus.wr_addr;
  assign bus2.wr_data = bus.wr_data;
  assign bus2.rd_addr = bus.rd_addr;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int n_ops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An accepted operation lasts len edges (1 same-address, 2 copy, 4 swap);
  // step counts edges since acceptance. Swap writes old B into A at step 2
  // and old A into B at step 3; copy writes old A into B at step 1.
  logic [7:0]  m_mem [16];
  bit          m_active;
  int          m_step, m_len;
  logic [3:0]  m_a, m_b;
  logic [7:0]  m_va, m_vb;
  logic [7:0]  e_rd;
  bit          e_rej;
  int unsigned m_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_active = 0; m_step = 0; m_len = 0;
      e_rd = 8'h00; e_rej = 0; m_cnt = 0;
    end else begin
      e_rd  = m_mem[bus.rd_addr];
      e_rej = bus.wr_en && m_active;
      if (!m_active) begin
        if (bus.wr_en) m_mem[bus.wr_addr] = bus.wr_data;
        if (bus.start) begin
          m_a = bus.addr_a; m_b = bus.addr_b;
          m_va = m_mem[m_a]; m_vb = m_mem[m_b];
          m_len = (m_a == m_b) ? 1 : (bus.mode ? 2 : 4);
          m_step = 0; m_active = 1;
          n_ops++;
          $display("op %0d: mode=%0d a=%0d b=%0d A=0x%02h B=0x%02h len=%0d",
                   n_ops, bus.mode, m_a, m_b, m_va, m_vb, m_len);
        end
      end else begin
        m_step++;
        if (m_len == 4 && m_step == 2) m_mem[m_a] = m_vb;
        if (m_len == 4 && m_step == 3) m_mem[m_b] = m_va;
        if (m_len == 2 && m_step == 1) m_mem[m_b] = m_va;
        if (m_step == m_len) begin m_active = 0; m_cnt++; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic e_done;
    e_done = m_active && (m_step == m_len - 1);
    chk("rd_data",   {24'd0, bus.rd_data}, {24'd0, e_rd});
    chk("busy",      {31'd0, bus.busy}, {31'd0, m_active});
    chk("done",      {31'd0, bus.done}, {31'd0, e_done});
    chk("wr_reject", {31'd0, bus.wr_reject}, {31'd0, e_rej});
    chk("op_cnt",    {16'd0, bus.op_cnt}, {16'd0, m_cnt[15:0]});
    chk("op_cnt_c2", {30'd0, bus2.op_cnt}, {30'd0, m_cnt[1:0]});
    chk("busy_c2",   {31'd0, bus2.busy}, {31'd0, m_active});
    chk("rd_data_c2", {24'd0, bus2.rd_data}, {24'd0, e_rd});
    if (bus.done) done_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [3:0] a, input logic [7:0] d);
    bus.rd_addr = a;
    tick();
    chk(name, {24'd0, bus.rd_data}, {24'd0, d});
  endtask

  task automatic run_op(input logic m, input logic [3:0] a, input logic [3:0] b,
                        output int cycles);
    bus.start = 1'b1; bus.mode = m; bus.addr_a = a; bus.addr_b = b;
    tick();
    bus.start = 1'b0;
    bus.addr_a = ~a; bus.addr_b = ~b; bus.mode = ~m;  // operands must stay latched
    cycles = 0;
    while (bus.busy && cycles < 20) begin
      tick();
      cycles++;
    end
    if (cycles >= 20) chk("op_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int lat;
    int d0;
    logic [1:0] wrap_seq [5];
    wrap_seq[0] = 2'd1; wrap_seq[1] = 2'd2; wrap_seq[2] = 2'd3;
    wrap_seq[3] = 2'd0; wrap_seq[4] = 2'd1;

    bus.start = 0; bus.mode = 0; bus.addr_a = 0; bus.addr_b = 0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.rd_addr = 0;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_op_cnt", {16'd0, bus.op_cnt}, 32'd0);
    reset_n = 1'b1;
    tick();

    // basic swap
    host_write(4'd2, 8'h11);
    host_write(4'd5, 8'h22);
    run_op(1'b0, 4'd2, 4'd5, lat);
    chk("swap_latency", lat, 32'd4);
    chk("swap_op_cnt", {16'd0, bus.op_cnt}, 32'd1);
    read_expect("swap_mem2", 4'd2, 8'h22);
    read_expect("swap_mem5", 4'd5, 8'h11);

    // copy
    host_write(4'd3, 8'hA5);
    run_op(1'b1, 4'd3, 4'd9, lat);
    chk("copy_latency", lat, 32'd2);
    chk("copy_op_cnt", {16'd0, bus.op_cnt}, 32'd2);
    read_expect("copy_mem9", 4'd9, 8'hA5);
    read_expect("copy_mem3", 4'd3, 8'hA5);

    // same address
    host_write(4'd7, 8'h3C);
    run_op(1'b0, 4'd7, 4'd7, lat);
    chk("same_latency", lat, 32'd1);
    chk("same_op_cnt", {16'd0, bus.op_cnt}, 32'd3);
    read_expect("same_mem7", 4'd7, 8'h3C);

    // host write and second start during a swap
    d0 = done_seen;
    bus.start = 1'b1; bus.mode = 1'b0; bus.addr_a = 4'd2; bus.addr_b = 4'd5;
    tick();
    bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 8'hFF;
    tick();
    bus.start = 1'b0; bus.wr_en = 1'b0;
    chk("reject_pulse", {31'd0, bus.wr_reject}, 32'd1);
    repeat (6) tick();
    chk("reject_one_done", done_seen - d0, 32'd1);
    chk("reject_op_cnt", {16'd0, bus.op_cnt}, 32'd4);
    read_expect("reject_mem2", 4'd2, 8'h11);
    read_expect("reject_mem5", 4'd5, 8'h22);

    // reset in WR_A
    bus.start = 1'b1; bus.mode = 1'b0; bus.addr_a = 4'd5; bus.addr_b = 4'd2;
    tick();
    bus.start = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_op_cnt", {16'd0, bus.op_cnt}, 32'd0);
    chk("abort_rd_data", {24'd0, bus.rd_data}, 32'd0);
    tick();
    reset_n = 1'b1;
    read_expect("abort_mem2", 4'd2, 8'h00);
    read_expect("abort_mem5", 4'd5, 8'h00);
    host_write(4'd1, 8'h5A);
    host_write(4'd4, 8'hC3);
    run_op(1'b0, 4'd1, 4'd4, lat);
    chk("fresh_latency", lat, 32'd4);
    read_expect("fresh_mem1", 4'd1, 8'hC3);
    read_expect("fresh_mem4", 4'd4, 8'h5A);

    // counter wrap on the CNT_W=2 build: counter is 1 here, reset to start clean
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    for (int k = 0; k < 5; k++) begin
      run_op(1'b0, 4'd6, 4'd6, lat);
      chk("wrap_op_cnt_c2", {30'd0, bus2.op_cnt}, {30'd0, wrap_seq[k]});
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.start   = ($urandom_range(0, 2) == 0);
      bus.mode    = $urandom_range(0, 1);
      bus.addr_a  = 4'($urandom_range(0, 15));
      bus.addr_b  = ($urandom_range(0, 7) == 0) ? bus.addr_a : 4'($urandom_range(0, 15));
      bus.wr_en   = ($urandom_range(0, 1) == 1);
      bus.wr_addr = 4'($urandom_range(0, 15));
      bus.wr_data = 8'($urandom_range(0, 255));
      bus.rd_addr = 4'($urandom_range(0, 15));
      reset_n     = ($urandom_range(0, 399) != 0);
      tick();
    end
    reset_n = 1'b1;
    bus.start = 0; bus.wr_en = 0;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_swap_ctrl.md
Name: mem_swap_ctrl

Overview:
- Parametrised register-file swap engine: a WIDTH x DEPTH storage array with a host write/read port and an FSM that exchanges two arbitrary entries (A<->B) through an internal temp register, or copies A->B.
- Generalises the fixed 3-step swap sequencer to arbitrary addresses and widths.
- Adds a start/busy/done handshake, a copy mode, host-write arbitration and a completion counter.
- Sits between the control bus and datapath consumers of the swapped storage.

Parameters:
- WIDTH, 8, data bits per entry.
- ADDR_W, 4, address bits; DEPTH = 2**ADDR_W entries (derived, not overridable).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  operation request, sampled only in IDLE.
- mode  in  1  0 = swap A<->B, 1 = copy A->B; latched with start.
- addr_a  in  ADDR_W  first operand address; latched with start.
- addr_b  in  ADDR_W  second operand address; latched with start.
- wr_en  in  1  host write strobe.
- wr_addr  in  ADDR_W  host write address.
- wr_data  in  WIDTH  host write data.
- rd_addr  in  ADDR_W  host read address.
- rd_data  out  WIDTH  registered read data.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle completion pulse.
- wr_reject  out  1  one-cycle pulse: host write dropped.
- op_cnt  out  CNT_W  count of completed operations.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all array entries, temp, rd_data and op_cnt cleared to 0; busy, done and wr_reject = 0. Reset asserted mid-operation aborts it immediately: no further writes, array cleared.
- States: IDLE, RD_A, WR_A, WR_B, COPY, DONE.
- IDLE: on edge E0 with start=1, latch mode/addr_a/addr_b and go to:
  - DONE if addr_a == addr_b (no array write, either mode);
  - else COPY if mode=1;
  - else RD_A.
- Swap sequence:
  - RD_A: temp <= mem[A]; -> WR_A.
  - WR_A: mem[A] <= mem[B]; -> WR_B.
  - WR_B: mem[B] <= temp; -> DONE.
- COPY: mem[B] <= mem[A]; -> DONE.
- DONE: done=1 for exactly this cycle; op_cnt += 1 (wraps modulo 2**CNT_W); -> IDLE.
- Latency from start edge E0:
  - swap: mem[A] updated at E2, mem[B] at E3, done high E3..E4, IDLE after E4 (4 cycles);
  - copy: done after E1 (2 cycles);
  - same-address: done after E0 (1 cycle).
- busy is state-decoded: rises the cycle after E0 and falls when the state returns to IDLE.
- start while busy is ignored (no queueing); start held high through DONE launches a new operation at the first IDLE edge.
- Host write:
  - performed only when state == IDLE at that edge; a simultaneous start is allowed, the write lands at E0 and the operation sees the new value.
  - wr_en when state != IDLE: write dropped; wr_reject=1 for the following cycle.
- Read port: rd_data <= mem[rd_addr] every edge, read-before-write (same-edge write returns old value). Reads are permitted while busy and return intermediate contents.
- Latched operands are immune to addr_a/addr_b/mode changes during busy.

Test Plan:
- Reset, then write mem[2]=0x11 and mem[5]=0x22; start, mode=0, A=2, B=5 -> busy for 4 cycles, done pulse on 4th, mem[2]=0x22, mem[5]=0x11, op_cnt=1.
- Copy: mem[3]=0xA5, start, mode=1, A=3, B=9 -> done after 2 cycles, mem[9]=0xA5, mem[3] unchanged, op_cnt increments.
- Same address: start with A=B=7 -> done after 1 cycle, mem[7] unchanged, op_cnt increments, no write observed.
- During a swap, assert wr_en to addr 2 with 0xFF and assert start again -> wr_reject pulses one cycle later, mem[2] not 0xFF, second start ignored, only one done.
- Assert reset_n=0 in WR_A of a swap -> immediately busy=0, done=0, all entries read 0, op_cnt=0; after release, a fresh swap completes normally.
- CNT_W=2 build: run 5 operations -> op_cnt sequence 1,2,3,0,1.
